draw_request_sequencer: RTL and testbench
=========================================

Name: draw_request_sequencer

Overview:
- Upstream feeder for the 4x4 block drawer, which raises ready_to_draw while idle and accepts one-cycle enable_start / enable_clear commands.
- Game logic pushes block-draw requests (x, y, colour) into a small FIFO and can post a screen-clear request.
- The sequencer issues one command at a time and holds x/y/colour stable until the drawer has latched them.
- It waits for the drawer to finish before issuing the next command.

Parameters:
- X_W, 8, width of x coordinate (160-pixel screen).
- Y_W, 7, width of y coordinate (120-line screen).
- C_W, 3, colour width.
- DEPTH, 8, FIFO entries; must be a power of 2.
- AW, 3, log2(DEPTH).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- push  in  1  enqueue push_x/push_y/push_colour this cycle.
- push_x  in  X_W  block top-left x.
- push_y  in  Y_W  block top-left y.
- push_colour  in  C_W  block colour.
- clear_req  in  1  request a full-screen clear (pulse or level; sampled every cycle).
- ready_to_draw  in  1  drawer idle indication.
- enable_start  out  1  one-cycle block-draw command to the drawer.
- enable_clear  out  1  one-cycle clear command to the drawer.
- x_out  out  X_W  coordinate presented to the drawer datapath.
- y_out  out  Y_W  coordinate presented to the drawer datapath.
- colour_out  out  C_W  colour presented to the drawer datapath.
- full  out  1  FIFO holds DEPTH entries.
- count  out  AW+1  current FIFO occupancy, 0..DEPTH.
- busy  out  1  high in any state other than IDLE, or while clear is pending, or while count != 0.

Behaviour:
- Reset (asynchronous) values: state=IDLE; FIFO pointers and count=0; clear_pending=0; enable_start, enable_clear, x_out, y_out, colour_out = 0; full=0; busy=0.
- All outputs are registered.
- FIFO:
  - Push while full is ignored: no write, no pointer change.
  - A push and a pop in the same cycle are both honoured, and count is unchanged.
  - Pointers wrap modulo DEPTH.
- clear_req handling:
  - clear_req=1 sets clear_pending and flushes the FIFO (pointers and count cleared) at that edge.
  - A push in the same cycle as clear_req is written after the flush, so count=1 afterwards.
  - clear_req while clear_pending=1 has no additional effect beyond the flush.
- State IDLE:
  - If ready_to_draw=1 and clear_pending=1: next state CLR. At that edge register enable_clear=1 and clear clear_pending. Clear has priority over queued blocks.
  - Else if ready_to_draw=1 and count>0: next state ISSUE. At that edge pop the head entry into x_out/y_out/colour_out and register enable_start=1.
  - Otherwise remain in IDLE.
- States ISSUE and CLR:
  - Exactly one cycle each.
  - The command output is high only in this cycle.
  - Next state is WAIT_BUSY.
- State WAIT_BUSY: stay until ready_to_draw=0, then go to WAIT_DONE.
- State WAIT_DONE: stay until ready_to_draw=1, then go to IDLE. The next command can be issued at the earliest one cycle after returning to IDLE.
- x_out/y_out/colour_out hold their value until the next pop. They are unchanged by CLR, so they remain valid while the drawer loads them.
- enable_start and enable_clear are never high together, and each is never high for 2 consecutive cycles.
- Latency: push at edge N with the FIFO empty, sequencer in IDLE and ready_to_draw=1 means enable_start is high in the cycle after edge N+1.
- clear_req arriving during a block draw:
  - The FIFO is flushed immediately.
  - The in-flight draw completes.
  - The clear is issued on the next IDLE with ready_to_draw=1.
- Reset asserted mid-operation returns the block to reset values immediately. Any in-flight drawer command is abandoned.

Test Plan:
- Reset, then push (x=8, y=4, colour=3'b100) with ready_to_draw=1 -> enable_start high for exactly 1 cycle, 2 cycles after the push edge, with x_out=8, y_out=4, colour_out=4, count back to 0.
- Push 3 entries back-to-back; model the drawer as ready_to_draw low for 18 cycles after each start -> 3 enable_start pulses in FIFO order, each only after ready_to_draw returns high; x_out stable between pulses.
- Push 9 entries with ready_to_draw=0 -> full=1 and count=8 after the 8th push; the 9th is dropped; release ready_to_draw -> exactly 8 draws, in the first 8 coordinates.
- Push 4 entries, then clear_req on the same cycle as a 5th push while a draw is in flight -> count=1 after that edge; the current draw finishes; enable_clear is issued before the remaining entry's enable_start.
- Simultaneous push and pop at count=2 -> count stays 2; the popped entry is the older one.
- Assert reset while in WAIT_BUSY with count=5 -> all outputs 0, count=0, state IDLE immediately (asynchronous); no command pulse after release until a new push.

Source files
------------

// File: rtl/draw_request_sequencer.sv
// Feeds the 4x4 block drawer: queues block-draw requests, posts screen clears, and
// issues one registered command at a time, waiting for the drawer to finish each one.
module draw_request_sequencer #(
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int C_W   = 3,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic [X_W-1:0] push_x,
  input  logic [Y_W-1:0] push_y,
  input  logic [C_W-1:0] push_colour,
  input  logic           clear_req,
  input  logic           ready_to_draw,
  output logic           enable_start,
  output logic           enable_clear,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic [C_W-1:0] colour_out,
  output logic           full,
  output logic [AW:0]    count,
  output logic           busy
);

  // Drawer handshake: a command is a one-cycle pulse while the drawer reports
  // ready_to_draw=1; the drawer is done once ready_to_draw has dropped and risen again.
  typedef enum logic [2:0] {IDLE, ISSUE, CLR, WAIT_BUSY, WAIT_DONE} state_t;

  localparam int             EW       = X_W + Y_W + C_W;
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);

  state_t         state_q, state_d;
  logic [EW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_addr;
  logic [AW:0]    count_q, count_d;
  logic           clear_pending_q, clear_pending_d;
  logic           en_start_q, en_start_d, en_clear_q, en_clear_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [C_W-1:0] c_q, c_d;
  logic           full_q, full_d, busy_q, busy_d;
  logic           do_pop, do_write;

  always_comb begin
    state_d         = state_q;
    clear_pending_d = clear_pending_q;
    en_start_d      = 1'b0;
    en_clear_d      = 1'b0;
    x_d             = x_q;
    y_d             = y_q;
    c_d             = c_q;
    do_pop          = 1'b0;

    case (state_q)
      IDLE: begin
        if (ready_to_draw && clear_pending_q) begin
          state_d    = CLR;
          en_clear_d = 1'b1;
        end else if (ready_to_draw && (count_q != '0)) begin
          state_d           = ISSUE;
          en_start_d        = 1'b1;
          do_pop            = 1'b1;
          {x_d, y_d, c_d}   = mem_q[rd_ptr_q];
        end
      end
      ISSUE, CLR: state_d = WAIT_BUSY;
      WAIT_BUSY:  if (!ready_to_draw) state_d = WAIT_DONE;
      WAIT_DONE:  if (ready_to_draw) state_d = IDLE;
      default:    state_d = IDLE;
    endcase

    // Issuing the clear consumes the pending flag; a clear_req at that edge only flushes.
    if (en_clear_d)     clear_pending_d = 1'b0;
    else if (clear_req) clear_pending_d = 1'b1;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_write = 1'b0;
    wr_addr  = wr_ptr_q;
    if (clear_req) begin
      // Flush first, then a same-cycle push lands in the emptied FIFO.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      wr_addr  = '0;
      if (push) begin
        do_write = 1'b1;
        wr_ptr_d = PTR_ONE;
        count_d  = CNT_ONE;
      end
    end else begin
      do_write = push && !full_q;
      if (do_write) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (do_write && !do_pop)      count_d = count_q + CNT_ONE;
      else if (!do_write && do_pop) count_d = count_q - CNT_ONE;
    end

    full_d = (count_d == CNT_FULL);
    busy_d = (state_d != IDLE) || clear_pending_d || (count_d != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      clear_pending_q <= 1'b0;
      en_start_q      <= 1'b0;
      en_clear_q      <= 1'b0;
      x_q             <= '0;
      y_q             <= '0;
      c_q             <= '0;
      full_q          <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      clear_pending_q <= clear_pending_d;
      en_start_q      <= en_start_d;
      en_clear_q      <= en_clear_d;
      x_q             <= x_d;
      y_q             <= y_d;
      c_q             <= c_d;
      full_q          <= full_d;
      busy_q          <= busy_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_addr] <= {push_x, push_y, push_colour};
  end

  assign enable_start = en_start_q;
  assign enable_clear = en_clear_q;
  assign x_out        = x_q;
  assign y_out        = y_q;
  assign colour_out   = c_q;
  assign full         = full_q;
  assign count        = count_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_draw_request_sequencer.sv
// Bench for draw_request_sequencer: directed steps plus a random soak, checked every
// cycle against a queue-based model of the command sequence and a simple drawer responder.
module tb_draw_request_sequencer;

  localparam int X_W = 8, Y_W = 7, C_W = 3, DEPTH = 8, AW = 3;
  localparam int EW = X_W + Y_W + C_W;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           reset;
  logic           push, clear_req, ready_to_draw;
  logic [X_W-1:0] push_x;
  logic [Y_W-1:0] push_y;
  logic [C_W-1:0] push_colour;
  logic           enable_start, enable_clear, full, busy;
  logic [X_W-1:0] x_out;
  logic [Y_W-1:0] y_out;
  logic [C_W-1:0] colour_out;
  logic [AW:0]    count;

  always #5 clk = ~clk;

  draw_request_sequencer #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .push(push), .push_x(push_x), .push_y(push_y),
    .push_colour(push_colour), .clear_req(clear_req), .ready_to_draw(ready_to_draw),
    .enable_start(enable_start), .enable_clear(enable_clear), .x_out(x_out),
    .y_out(y_out), .colour_out(colour_out), .full(full), .count(count), .busy(busy)
  );

  // ---------------- reference model ----------------
  logic [EW-1:0]  exp_q[$];     // pending block requests, oldest first
  int             m_phase;      // 0 free, 1 command cycle, 2 await drawer busy, 3 await drawer done
  bit             m_clear;
  bit             e_start, e_clear;
  logic [X_W-1:0] ex;
  logic [Y_W-1:0] ey;
  logic [C_W-1:0] ec;

  int n_checks = 0, n_fail = 0;
  int obs_starts = 0, obs_clears = 0;
  logic [1:0] cmd_log[$];       // 1 = clear seen, 2 = start seen
  bit auto_drw, drw_latch;
  int drw_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_phase = 0; m_clear = 0; e_start = 0; e_clear = 0;
    ex = '0; ey = '0; ec = '0;
    drw_latch = 0; drw_cnt = 0;
  endtask

  // Applies the inputs present at a rising edge to the model.
  task automatic model_edge();
    int sz0;
    logic [EW-1:0] head;
    sz0 = exp_q.size();
    e_start = 0; e_clear = 0;
    case (m_phase)
      0: if (ready_to_draw && m_clear) begin
           e_clear = 1; m_phase = 1;
         end else if (ready_to_draw && sz0 > 0) begin
           head = exp_q.pop_front();
           {ex, ey, ec} = head;
           e_start = 1; m_phase = 1;
         end
      1: m_phase = 2;
      2: if (!ready_to_draw) m_phase = 3;
      default: if (ready_to_draw) m_phase = 0;
    endcase
    if (e_clear) m_clear = 0;
    else if (clear_req) m_clear = 1;
    if (clear_req) exp_q.delete();
    if (push && (clear_req || sz0 < DEPTH)) exp_q.push_back({push_x, push_y, push_colour});
  endtask

  task automatic check_all();
    chk("enable_start", 32'(enable_start), 32'(e_start));
    chk("enable_clear", 32'(enable_clear), 32'(e_clear));
    chk("x_out", 32'(x_out), 32'(ex));
    chk("y_out", 32'(y_out), 32'(ey));
    chk("colour_out", 32'(colour_out), 32'(ec));
    chk("count", 32'(count), 32'(exp_q.size()));
    chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
    chk("busy", 32'(busy), 32'((m_phase != 0) || m_clear || (exp_q.size() != 0)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (enable_start) begin obs_starts++; cmd_log.push_back(2'd2); end
    if (enable_clear) begin obs_clears++; cmd_log.push_back(2'd1); end
    push = 0; clear_req = 0;
    // Drawer responder: latches a command, then stays busy for 18 cycles.
    if (auto_drw) begin
      if (drw_cnt > 0) begin
        drw_cnt--;
        if (drw_cnt == 0) ready_to_draw = 1;
      end else if (drw_latch) begin
        drw_latch = 0; ready_to_draw = 0; drw_cnt = 18;
      end
      if (e_start || e_clear) drw_latch = 1;
    end
  endtask

  task automatic do_push(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                         input logic [C_W-1:0] c);
    push = 1; push_x = x; push_y = y; push_colour = c;
    tick();
  endtask

  task automatic rand_push();
    do_push(8'($urandom_range(0, 159)), 7'($urandom_range(0, 119)), 3'($urandom));
  endtask

  task automatic drain(input string tag);
    bit done;
    for (int i = 0; i < 600; i++) begin
      if (m_phase == 0 && !m_clear && exp_q.size() == 0 && ready_to_draw) break;
      tick();
    end
    done = (m_phase == 0 && !m_clear && exp_q.size() == 0);
    chk(tag, 32'(done), 1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int s0;
    logic [X_W-1:0] xa, x5;
    reset = 1; push = 0; clear_req = 0; ready_to_draw = 1;
    push_x = '0; push_y = '0; push_colour = '0; auto_drw = 0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset = 0;

    // Single request: command two edges after the push edge
    auto_drw = 1;
    do_push(8'd8, 7'd4, 3'b100);
    chk("t1_no_early_start", 32'(enable_start), 0);
    tick();
    chk("t1_start", 32'(enable_start), 1);
    chk("t1_x", 32'(x_out), 8);
    chk("t1_y", 32'(y_out), 4);
    chk("t1_colour", 32'(colour_out), 4);
    chk("t1_count", 32'(count), 0);
    tick();
    chk("t1_start_one_cycle", 32'(enable_start), 0);
    drain("t1_drain");

    // Three back-to-back requests, drawer busy 18 cycles each
    s0 = obs_starts;
    for (int i = 0; i < 3; i++) rand_push();
    drain("t2_drain");
    chk("t2_starts", 32'(obs_starts - s0), 3);

    // Overfill with drawer held off: ninth push dropped
    auto_drw = 0; ready_to_draw = 0;
    for (int i = 0; i < 9; i++) begin
      rand_push();
      if (i == 7) begin
        chk("t3_full", 32'(full), 1);
        chk("t3_count8", 32'(count), 8);
      end
    end
    chk("t3_count_after_drop", 32'(count), 8);
    s0 = obs_starts;
    ready_to_draw = 1; auto_drw = 1;
    drain("t3_drain");
    chk("t3_draws", 32'(obs_starts - s0), 8);

    // Clear with a same-cycle push while a draw is in flight
    for (int i = 0; i < 4; i++) rand_push();
    tick(); tick(); tick();
    cmd_log.delete();
    x5 = 8'($urandom_range(0, 159));
    clear_req = 1;
    do_push(x5, 7'd17, 3'd5);
    chk("t4_count1", 32'(count), 1);
    drain("t4_drain");
    chk("t4_cmds", 32'(cmd_log.size()), 2);
    if (cmd_log.size() == 2) begin
      chk("t4_clear_first", 32'(cmd_log[0]), 1);
      chk("t4_start_second", 32'(cmd_log[1]), 2);
    end
    chk("t4_last_x", 32'(x_out), 32'(x5));

    // Simultaneous push and pop at count 2
    auto_drw = 0; ready_to_draw = 0;
    xa = 8'($urandom_range(0, 159));
    do_push(xa, 7'd1, 3'd1);
    rand_push();
    chk("t5_count2", 32'(count), 2);
    ready_to_draw = 1; auto_drw = 1;
    rand_push();
    chk("t5_count_kept", 32'(count), 2);
    chk("t5_pop_oldest", 32'(x_out), 32'(xa));
    drain("t5_drain");

    // Random soak with occasional clears
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 40) == 0) clear_req = 1;
      if ($urandom_range(0, 2) == 0) rand_push();
      else tick();
    end
    drain("soak_drain");

    // Asynchronous reset while waiting on the drawer with five queued entries
    auto_drw = 0; ready_to_draw = 1;
    rand_push();
    tick(); tick();
    for (int i = 0; i < 5; i++) rand_push();
    chk("t6_count5", 32'(count), 5);
    #3 reset = 1;
    #1;
    chk("t6_rst_start", 32'(enable_start), 0);
    chk("t6_rst_clear", 32'(enable_clear), 0);
    chk("t6_rst_x", 32'(x_out), 0);
    chk("t6_rst_y", 32'(y_out), 0);
    chk("t6_rst_colour", 32'(colour_out), 0);
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_full", 32'(full), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    model_reset();
    @(negedge clk);
    reset = 0;
    s0 = obs_starts;
    for (int i = 0; i < 10; i++) tick();
    chk("t6_no_cmd_after_reset", 32'(obs_starts - s0), 0);
    auto_drw = 1;
    rand_push();
    tick();
    chk("t6_new_push_start", 32'(enable_start), 1);
    drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
